// File: rtl/wrap_multi_fifo_pkg.sv
// Shared defaults, derived widths and helpers for the
// multi-port wrap-around queue.
package wrap_multi_fifo_pkg;

  localparam int unsigned DEF_DATA_NBITS = 8;
  localparam int unsigned DEF_SIZE       = 4;
  localparam int unsigned DEF_MAX_OPS    = 2;

  localparam int unsigned DEF_PTR_NBITS = $clog2(DEF_SIZE);
  localparam int unsigned DEF_CNT_NBITS = $clog2(DEF_SIZE + 1);
  localparam int unsigned DEF_OPS_NBITS = $clog2(DEF_MAX_OPS + 1);

  function automatic int unsigned min_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/ptr_wrap_adv.sv
// Combinational wrap-advance of a pointer by 0..MAX_OPS
// single steps, plus per-lane slot indices ptr+0..ptr+MAX_OPS-1.
module ptr_wrap_adv
  import wrap_multi_fifo_pkg::*;
#(
  parameter int unsigned SIZE    = DEF_SIZE,
  parameter int unsigned MAX_OPS = DEF_MAX_OPS,
  localparam int unsigned PTR_NBITS = $clog2(SIZE),
  localparam int unsigned OPS_NBITS = $clog2(MAX_OPS + 1)
) (
  input  logic [PTR_NBITS-1:0]              ptr,
  input  logic [OPS_NBITS-1:0]              cnt,
  output logic [MAX_OPS-1:0][PTR_NBITS-1:0] lanes,
  output logic [PTR_NBITS-1:0]              adv
);

  // Chained single steps keep non-power-of-2 sizes correct.
  function automatic logic [PTR_NBITS-1:0] step_n(
    input logic [PTR_NBITS-1:0] p,
    input int unsigned          n
  );
    logic [PTR_NBITS-1:0] q;
    q = p;
    for (int unsigned j = 0; j < n; j++)
      q = (q == PTR_NBITS'(SIZE - 1)) ? '0 : q + 1'b1;
    return q;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < MAX_OPS; i++)
      lanes[i] = step_n(ptr, i);
  end

  always_comb begin
    adv = ptr;
    for (int unsigned i = 1; i <= MAX_OPS; i++)
      if (cnt == OPS_NBITS'(i))
        adv = step_n(ptr, i);
  end

endmodule

// File: rtl/wrap_multi_fifo.sv
// Circular queue with up to MAX_OPS enqueues and dequeues
// per cycle; occupancy disambiguates full from empty.
module wrap_multi_fifo
  import wrap_multi_fifo_pkg::*;
#(
  parameter int unsigned DATA_NBITS = DEF_DATA_NBITS,
  parameter int unsigned SIZE       = DEF_SIZE,
  parameter int unsigned MAX_OPS    = DEF_MAX_OPS,
  localparam int unsigned PTR_NBITS = $clog2(SIZE),
  localparam int unsigned CNT_NBITS = $clog2(SIZE + 1),
  localparam int unsigned OPS_NBITS = $clog2(MAX_OPS + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [OPS_NBITS-1:0]               enq_count,
  input  logic [MAX_OPS-1:0][DATA_NBITS-1:0] enq_data,
  output logic [OPS_NBITS-1:0]               enq_rdy_count,
  input  logic [OPS_NBITS-1:0]               deq_count,
  output logic [MAX_OPS-1:0][DATA_NBITS-1:0] deq_data,
  output logic [OPS_NBITS-1:0]               deq_valid_count,
  output logic [CNT_NBITS-1:0]               occupancy
);

  localparam int unsigned SUM_NBITS = CNT_NBITS + 1;

  logic [DATA_NBITS-1:0] mem [SIZE];
  logic [PTR_NBITS-1:0]  head;
  logic [PTR_NBITS-1:0]  tail;
  logic [PTR_NBITS-1:0]  head_adv;
  logic [PTR_NBITS-1:0]  tail_adv;
  logic [MAX_OPS-1:0][PTR_NBITS-1:0] rd_idx;
  logic [MAX_OPS-1:0][PTR_NBITS-1:0] wr_idx;
  logic [CNT_NBITS-1:0]  free;
  logic [OPS_NBITS-1:0]  eff_enq;
  logic [OPS_NBITS-1:0]  eff_deq;
  logic [CNT_NBITS-1:0]  occ_next;

  // Readiness uses current free space only, no same-cycle credit.
  assign free = CNT_NBITS'(SIZE) - occupancy;
  assign enq_rdy_count =
    OPS_NBITS'(min_u(32'(free), MAX_OPS));
  assign deq_valid_count =
    OPS_NBITS'(min_u(32'(occupancy), MAX_OPS));

  assign eff_enq =
    OPS_NBITS'(min_u(32'(enq_count), 32'(enq_rdy_count)));
  assign eff_deq =
    OPS_NBITS'(min_u(32'(deq_count), 32'(deq_valid_count)));

  assign occ_next = CNT_NBITS'(
    {1'b0, occupancy}
    + SUM_NBITS'(eff_enq)
    - SUM_NBITS'(eff_deq));

  ptr_wrap_adv #(
    .SIZE    (SIZE),
    .MAX_OPS (MAX_OPS)
  ) u_head_adv (
    .ptr   (head),
    .cnt   (eff_deq),
    .lanes (rd_idx),
    .adv   (head_adv)
  );

  ptr_wrap_adv #(
    .SIZE    (SIZE),
    .MAX_OPS (MAX_OPS)
  ) u_tail_adv (
    .ptr   (tail),
    .cnt   (eff_enq),
    .lanes (wr_idx),
    .adv   (tail_adv)
  );

  always_comb begin
    for (int unsigned i = 0; i < MAX_OPS; i++)
      deq_data[i] = mem[rd_idx[i]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      occupancy <= '0;
      for (int unsigned i = 0; i < SIZE; i++)
        mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < MAX_OPS; i++)
        if (OPS_NBITS'(i) < eff_enq)
          mem[wr_idx[i]] <= enq_data[i];
      head      <= head_adv;
      tail      <= tail_adv;
      occupancy <= occ_next;
    end
  end

endmodule
